y86_fde_core: RTL and testbench
===============================

# y86_fde_core

Combinational fetch, decode and execute datapath of the single-cycle Y86-64 processor, plus the condition-code register and branch/move condition logic. It sits between the instruction memory, the register file (read ports) and the memory/write-back logic. It decodes an instruction window into fields, register IDs, the next sequential PC and the ALU result. The only state is the 3-bit CC register.

## Interface
Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- pc  in  64  address of current instruction
- ins  in  80  10 instruction bytes starting at pc; byte k = ins[79-8k -: 8]
- imem_err  in  1  instruction memory fault
- valA  in  64  register file value of srcA
- valB  in  64  register file value of srcB
- icode, ifun, rA, rB  out  4 each  decoded fields
- valC  out  64  immediate constant
- valP  out  64  next sequential PC
- instr_valid, need_regids, need_valC  out  1 each  decode flags
- srcA, srcB, dstE, dstM  out  4 each  register IDs; 4'hF = none
- valE  out  64  ALU result
- set_cc  out  1  CC update enable for this instruction
- cc  out  3  registered flags {ZF,SF,OF}
- Cnd  out  1  condition result for cmov/jxx

## Operation
- icode codes: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq. RSP = 4.
- Field decode: icode = byte0[7:4], ifun = byte0[3:0], rA = byte1[7:4], rB = byte1[3:0].
- need_regids is set for icode in {2,3,4,5,6,A,B}.
- need_valC is set for icode in {3,4,5,7,8}.
- valC is little-endian, taken from bytes 2..9 if need_regids, else bytes 1..8. valC is 0 when need_valC = 0.
- valP = pc + 1 + need_regids + 8·need_valC, mod 2^64.
- instr_valid is 1 only when all three hold:
  - icode <= B
  - ifun <= 3 for OPq, and ifun <= 6 for cmov/jXX
  - ifun = 0 for all other icodes
- If imem_err or !instr_valid: srcA/srcB/dstE/dstM = F, set_cc = 0, valE = 0.
- srcA = rA for {2,4,6,A}; RSP for {9,B}; else F.
- srcB = rB for {4,5,6}; RSP for {8,9,A,B}; else F.
- dstE = rB for {3,6}, and for 2 when Cnd = 1; RSP for {8,9,A,B}; else F.
- dstM = rA for {5,B}; else F.
- ALU operand A (aluA):
  - valA for {2,6}
  - valC for {3,4,5}
  - −8 for {8,A}
  - +8 for {9,B}
  - 0 otherwise
- ALU operand B (aluB): valB for {4,5,6,8,9,A,B}; 0 otherwise.
- ALU function is ifun for OPq and add for every other icode:
  - add: valE = aluB + aluA
  - sub: valE = aluB − aluA
  - and: valE = aluB & aluA
  - xor: valE = aluB ^ aluA
- Arithmetic wraps to 64 bits.
- set_cc = 1 only for a valid OPq.
- Next flags:
  - ZF = (valE == 0), SF = valE[63].
  - OF for add = (aluA[63] == aluB[63]) && (valE[63] != aluA[63]).
  - OF for sub = (aluA[63] != aluB[63]) && (valE[63] != aluB[63]).
  - OF = 0 for and/xor.
- Cnd is evaluated from registered cc for icode 2 or 7:
  - ifun 0 always → 1
  - 1 le → (SF^OF)|ZF
  - 2 l → SF^OF
  - 3 e → ZF
  - 4 ne → !ZF
  - 5 ge → !(SF^OF)
  - 6 g → !(SF^OF)&!ZF
  - ifun > 6 → 0
- Cnd = 0 for all other icodes.

## Timing
- All outputs except cc are purely combinational from the inputs and cc, with zero-cycle latency.
- cc is loaded with {ZF,SF,OF} on the rising edge of clk when set_cc = 1; otherwise it holds.
- Cnd therefore uses flags set by earlier instructions, never by the current OPq.
- rst asserted forces cc = 3'b100 (ZF=1, SF=0, OF=0) immediately, regardless of clk. While rst is high, cc holds this value.
- Combinational outputs keep functioning during reset.
- No handshake: the consumer samples outputs before the next rising edge.

## Test plan
- Reset: pulse rst mid-cycle → cc = 3'b100 immediately. With icode 7, ifun 3 (je) → Cnd = 1.
- irmovq $0x0123456789ABCDEF,%rbx at pc=0x10 → instr_valid = 1, need_regids = 1, need_valC = 1, rB = 3, valC = 0x0123456789ABCDEF, valP = 0x1A, dstE = 3, valE = valC, set_cc = 0.
- subq %rax,%rbx with valA = 5, valB = 5 → valE = 0, set_cc = 1. After the edge, cc = 3'b100.
- addq with valA = valB = 0x7FFFFFFFFFFFFFFF → valE = 0xFFFFFFFFFFFFFFFE, cc after the edge = 3'b011. Then jl → Cnd = 0 and jle → Cnd = 0. With cc = 3'b010, jl → Cnd = 1.
- pushq %rcx with valB = 0x100 → srcA = 1, srcB = 4, dstE = 4, valE = 0xF8, valP = pc + 2. call 0x40 → valE = valB − 8, valP = pc + 9.
- Invalid cases:
  - icode = C → instr_valid = 0, all register IDs = F, set_cc = 0.
  - imem_err = 1 with a valid OPq → set_cc = 0, and cc is unchanged after the edge.

Source files
------------

// File: rtl/y86_fde_core.sv
// Single-cycle Y86-64 fetch/decode/execute datapath with the condition-code register.
// Everything is combinational except cc_o, which latches ALU flags after a valid OPq.
module y86_fde_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_i,
  input  logic [79:0] ins_i,
  input  logic        imem_err_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valB_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic        instr_valid_o,
  output logic        need_regids_o,
  output logic        need_valC_o,
  output logic [3:0]  srcA_o,
  output logic [3:0]  srcB_o,
  output logic [3:0]  dstE_o,
  output logic [3:0]  dstM_o,
  output logic [63:0] valE_o,
  output logic        set_cc_o,
  output logic [2:0]  cc_o,
  output logic        Cnd_o
);
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3,
                         I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
                         I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
  localparam logic [3:0] R_RSP = 4'h4, R_NONE = 4'hF;

  logic [7:0]  byte_w [10];
  logic [63:0] c_reg, c_nor;
  logic        ok, zf, sf, of, cond;
  logic [1:0]  alu_fn;
  logic [63:0] aluA, aluB, alu_res;
  logic        ovf;
  logic [2:0]  cc_d, cc_q;

  always_comb begin
    for (int k = 0; k < 10; k++) byte_w[k] = ins_i[79-8*k -: 8];
    // valC is little-endian: lowest byte sits right after the opcode/register bytes
    for (int k = 0; k < 8; k++) begin
      c_reg[8*k +: 8] = byte_w[k+2];
      c_nor[8*k +: 8] = byte_w[k+1];
    end
  end

  assign icode_o = byte_w[0][7:4];
  assign ifun_o  = byte_w[0][3:0];
  assign rA_o    = byte_w[1][7:4];
  assign rB_o    = byte_w[1][3:0];

  always_comb begin
    need_regids_o = icode_o inside {I_RRMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OPQ, I_PUSH, I_POP};
    need_valC_o   = icode_o inside {I_IRMOV, I_RMMOV, I_MRMOV, I_JXX, I_CALL};
    unique case (icode_o)
      I_OPQ:          instr_valid_o = (ifun_o <= 4'd3);
      I_RRMOV, I_JXX: instr_valid_o = (ifun_o <= 4'd6);
      I_HALT, I_NOP, I_IRMOV, I_RMMOV, I_MRMOV, I_CALL, I_RET, I_PUSH, I_POP:
                      instr_valid_o = (ifun_o == 4'd0);
      default:        instr_valid_o = 1'b0;
    endcase
  end

  assign valC_o = !need_valC_o ? 64'd0 : (need_regids_o ? c_reg : c_nor);
  assign valP_o = pc_i + 64'd1 + {63'd0, need_regids_o} + (need_valC_o ? 64'd8 : 64'd0);
  assign ok     = instr_valid_o && !imem_err_i;

  // Condition uses the registered flags, i.e. those of an earlier OPq
  assign {zf, sf, of} = cc_q;
  always_comb begin
    unique case (ifun_o)
      4'd0:    cond = 1'b1;
      4'd1:    cond = (sf ^ of) | zf;
      4'd2:    cond = sf ^ of;
      4'd3:    cond = zf;
      4'd4:    cond = !zf;
      4'd5:    cond = !(sf ^ of);
      4'd6:    cond = !(sf ^ of) && !zf;
      default: cond = 1'b0;
    endcase
    Cnd_o = (icode_o == I_RRMOV || icode_o == I_JXX) ? cond : 1'b0;
  end

  always_comb begin
    srcA_o = R_NONE;
    srcB_o = R_NONE;
    dstE_o = R_NONE;
    dstM_o = R_NONE;
    if (ok) begin
      if (icode_o inside {I_RRMOV, I_RMMOV, I_OPQ, I_PUSH}) srcA_o = rA_o;
      else if (icode_o inside {I_RET, I_POP})               srcA_o = R_RSP;
      if (icode_o inside {I_RMMOV, I_MRMOV, I_OPQ})          srcB_o = rB_o;
      else if (icode_o inside {I_CALL, I_RET, I_PUSH, I_POP}) srcB_o = R_RSP;
      if (icode_o inside {I_IRMOV, I_OPQ} || (icode_o == I_RRMOV && Cnd_o)) dstE_o = rB_o;
      else if (icode_o inside {I_CALL, I_RET, I_PUSH, I_POP})              dstE_o = R_RSP;
      if (icode_o inside {I_MRMOV, I_POP}) dstM_o = rA_o;
    end
  end

  always_comb begin
    unique case (icode_o)
      I_RRMOV, I_OPQ:           aluA = valA_i;
      I_IRMOV, I_RMMOV, I_MRMOV: aluA = valC_o;
      I_CALL, I_PUSH:           aluA = -64'sd8;
      I_RET, I_POP:             aluA = 64'd8;
      default:                  aluA = 64'd0;
    endcase
    aluB   = (icode_o inside {I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP}) ? valB_i : 64'd0;
    alu_fn = (icode_o == I_OPQ) ? ifun_o[1:0] : 2'd0;
    unique case (alu_fn)
      2'd0:    alu_res = aluB + aluA;
      2'd1:    alu_res = aluB - aluA;
      2'd2:    alu_res = aluB & aluA;
      default: alu_res = aluB ^ aluA;
    endcase
    unique case (alu_fn)
      2'd0:    ovf = (aluA[63] == aluB[63]) && (alu_res[63] != aluA[63]);
      2'd1:    ovf = (aluA[63] != aluB[63]) && (alu_res[63] != aluB[63]);
      default: ovf = 1'b0;
    endcase
  end

  assign valE_o   = ok ? alu_res : 64'd0;
  assign set_cc_o = ok && (icode_o == I_OPQ);
  assign cc_d     = set_cc_o ? {alu_res == 64'd0, alu_res[63], ovf} : cc_q;
  assign cc_o     = cc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cc_q <= 3'b100;
    else     cc_q <= cc_d;
  end
endmodule

// File: tb/tb_y86_fde_core.sv
// Directed-vector bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_y86_fde_core;
  logic        clk = 1'b0, rst = 1'b1;
  logic [63:0] pc_i = '0, valA_i = '0, valB_i = '0;
  logic [79:0] ins_i = '0;
  logic        imem_err_i = 1'b0;
  logic [3:0]  icode_o, ifun_o, rA_o, rB_o, srcA_o, srcB_o, dstE_o, dstM_o;
  logic [63:0] valC_o, valP_o, valE_o;
  logic        instr_valid_o, need_regids_o, need_valC_o, set_cc_o, Cnd_o;
  logic [2:0]  cc_o;

  y86_fde_core dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ins_i(ins_i), .imem_err_i(imem_err_i),
    .valA_i(valA_i), .valB_i(valB_i), .icode_o(icode_o), .ifun_o(ifun_o),
    .rA_o(rA_o), .rB_o(rB_o), .valC_o(valC_o), .valP_o(valP_o),
    .instr_valid_o(instr_valid_o), .need_regids_o(need_regids_o), .need_valC_o(need_valC_o),
    .srcA_o(srcA_o), .srcB_o(srcB_o), .dstE_o(dstE_o), .dstM_o(dstM_o),
    .valE_o(valE_o), .set_cc_o(set_cc_o), .cc_o(cc_o), .Cnd_o(Cnd_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        iv, nr, nc;
    logic [3:0]  rA, rB, srcA, srcB, dstE, dstM;
    logic [63:0] valC, valP, valE;
    logic        set_cc, cnd;
    logic [2:0]  cc;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;

  function automatic logic [63:0] le(input logic [63:0] c);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[63-8*k -: 8] = c[8*k +: 8];
    return r;
  endfunction

  function automatic exp_t e(input string n, input logic iv, nr, nc,
                             input logic [3:0] rA, rB, sA, sB, dE, dM,
                             input logic [63:0] vC, vP, vE, input logic sc, cnd, input logic [2:0] cc);
    exp_t x;
    x.name = n; x.iv = iv; x.nr = nr; x.nc = nc; x.rA = rA; x.rB = rB;
    x.srcA = sA; x.srcB = sB; x.dstE = dE; x.dstM = dM;
    x.valC = vC; x.valP = vP; x.valE = vE; x.set_cc = sc; x.cnd = cnd; x.cc = cc;
    return x;
  endfunction

  task automatic chk(input string vec, input string fld, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s.%s: got %h, expected %h", vec, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk(x.name, "instr_valid", 64'(instr_valid_o), 64'(x.iv));
      chk(x.name, "need_regids", 64'(need_regids_o), 64'(x.nr));
      chk(x.name, "need_valC",   64'(need_valC_o),   64'(x.nc));
      chk(x.name, "rA",   64'(rA_o),   64'(x.rA));
      chk(x.name, "rB",   64'(rB_o),   64'(x.rB));
      chk(x.name, "srcA", 64'(srcA_o), 64'(x.srcA));
      chk(x.name, "srcB", 64'(srcB_o), 64'(x.srcB));
      chk(x.name, "dstE", 64'(dstE_o), 64'(x.dstE));
      chk(x.name, "dstM", 64'(dstM_o), 64'(x.dstM));
      chk(x.name, "valC", valC_o, x.valC);
      chk(x.name, "valP", valP_o, x.valP);
      chk(x.name, "valE", valE_o, x.valE);
      chk(x.name, "set_cc", 64'(set_cc_o), 64'(x.set_cc));
      chk(x.name, "Cnd",    64'(Cnd_o),    64'(x.cnd));
      chk(x.name, "cc",     64'(cc_o),     64'(x.cc));
    end
  end

  // Drive one instruction just after a rising edge and queue its expected response
  task automatic apply(input logic [63:0] pc, input logic [79:0] ins, input logic [63:0] a, b,
                       input logic err, input exp_t x);
    @(posedge clk); #1;
    pc_i = pc; ins_i = ins; valA_i = a; valB_i = b; imem_err_i = err;
    q.push_back(x);
  endtask

  localparam logic [3:0] F = 4'hF;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF, MSB = 64'h8000_0000_0000_0000;

  initial begin
    // reset held: je reads cc = ZF -> taken
    apply(64'h0, {8'h73, le(64'h40), 8'h00}, 0, 0, 0,
          e("reset_je", 1,0,1, 4,0, F,F,F,F, 64'h40, 64'h9, 0, 0,1, 3'b100));
    @(negedge clk); #1 rst = 1'b0;
    apply(64'h10, {8'h30, 8'hF3, le(64'h0123456789ABCDEF)}, 0, 0, 0,
          e("irmovq", 1,1,1, F,3, F,F,3,F, 64'h0123456789ABCDEF, 64'h1A, 64'h0123456789ABCDEF, 0,0, 3'b100));
    apply(64'h1A, {8'h61, 8'h03, 64'h0}, 5, 5, 0,
          e("subq_zero", 1,1,0, 0,3, 0,3,3,F, 0, 64'h1C, 0, 1,0, 3'b100));
    apply(64'h1C, {8'h60, 8'h03, 64'h0}, MAXP, MAXP, 0,
          e("addq_ovf", 1,1,0, 0,3, 0,3,3,F, 0, 64'h1E, 64'hFFFF_FFFF_FFFF_FFFE, 1,0, 3'b100));
    apply(64'h100, {8'h72, le(64'h40), 8'h00}, 0, 0, 0,
          e("jl_cc011", 1,0,1, 4,0, F,F,F,F, 64'h40, 64'h109, 0, 0,0, 3'b011));
    apply(64'h100, {8'h71, le(64'h40), 8'h00}, 0, 0, 0,
          e("jle_cc011", 1,0,1, 4,0, F,F,F,F, 64'h40, 64'h109, 0, 0,0, 3'b011));
    apply(64'h200, {8'h63, 8'h12, 64'h0}, MSB, 0, 0,
          e("xorq", 1,1,0, 1,2, 1,2,2,F, 0, 64'h202, MSB, 1,0, 3'b011));
    apply(64'h100, {8'h72, le(64'h40), 8'h00}, 0, 0, 0,
          e("jl_cc010", 1,0,1, 4,0, F,F,F,F, 64'h40, 64'h109, 0, 0,1, 3'b010));
    apply(64'h300, {8'h22, 8'h12, 64'h0}, 64'h55, 64'h999, 0,
          e("cmovl", 1,1,0, 1,2, 1,F,2,F, 0, 64'h302, 64'h55, 0,1, 3'b010));
    apply(64'h400, {8'hA0, 8'h1F, 64'h0}, 64'h77, 64'h100, 0,
          e("pushq", 1,1,0, 1,F, 1,4,4,F, 0, 64'h402, 64'hF8, 0,0, 3'b010));
    apply(64'h500, {8'h80, le(64'h40), 8'h00}, 0, 64'h200, 0,
          e("call", 1,0,1, 4,0, F,4,4,F, 64'h40, 64'h509, 64'h1F8, 0,0, 3'b010));
    apply(64'h600, {8'hB0, 8'h6F, 64'h0}, 0, 64'h1F8, 0,
          e("popq", 1,1,0, 6,F, 4,4,4,6, 0, 64'h602, 64'h200, 0,0, 3'b010));
    apply(64'h700, {8'hC0, 8'h12, 64'h0}, 1, 2, 0,
          e("bad_icode", 0,0,0, 1,2, F,F,F,F, 0, 64'h701, 0, 0,0, 3'b010));
    apply(64'h800, {8'h61, 8'h03, 64'h0}, 1, 1, 1,
          e("imem_err", 1,1,0, 0,3, F,F,F,F, 0, 64'h802, 0, 0,0, 3'b010));
    apply(64'h900, {8'h10, 72'h0}, 0, 0, 0,
          e("nop_cc_held", 1,0,0, 0,0, F,F,F,F, 0, 64'h901, 0, 0,0, 3'b010));
    apply(64'hA00, {8'h64, 8'h03, 64'h0}, 3, 3, 0,
          e("bad_opq", 0,1,0, 0,3, F,F,F,F, 0, 64'hA02, 0, 0,0, 3'b010));
    // mid-cycle reset pulse must clear cc without waiting for an edge
    apply(64'h0, {8'h73, le(64'h40), 8'h00}, 0, 0, 0,
          e("rst_pulse_je", 1,0,1, 4,0, F,F,F,F, 64'h40, 64'h9, 0, 0,1, 3'b100));
    #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d vectors unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
